collision_scheduler: RTL and testbench

//  Per-frame sequencer for the shared pairwise collision resolver. On each frame

---
 rtl/collision_scheduler_if.sv | 20 ++
 rtl/collision_scheduler.sv | 113 +++++++++++
 tb/tb_collision_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/collision_scheduler_if.sv
// collision_scheduler_if: frame control, ball-table read and resolver handshake bundle.
// master = scheduler side, slave = ball table / resolver / frame logic side.
interface collision_scheduler_if #(parameter int IDX_W = 2);
   logic             start;
   logic [IDX_W-1:0] rd_a_idx, rd_b_idx;
   logic [9:0]       xa, ya, xb, yb;
   logic             res_req;
   logic [IDX_W-1:0] res_a_idx, res_b_idx;
   logic             res_ack;
   logic             busy, done;
   logic [7:0]       hit_count;
   modport master (
      input  start, xa, ya, xb, yb, res_ack,
      output rd_a_idx, rd_b_idx, res_req, res_a_idx, res_b_idx, busy, done, hit_count
   );
   modport slave (
      output start, xa, ya, xb, yb, res_ack,
      input  rd_a_idx, rd_b_idx, res_req, res_a_idx, res_b_idx, busy, done, hit_count
   );
endinterface

// File: rtl/collision_scheduler.sv
// collision_scheduler: per-frame pair walker feeding one collision resolver over req/ack.
// Define COLLISION_COOLDOWN_EN to keep a per-pair contact mask so each contact is resolved once.
module collision_scheduler #(
   parameter int N_BALLS = 4,
   parameter int IDX_W   = 2,
   parameter int BALL_D  = 24
) (
   input logic                   clk,
   input logic                   rst,
   collision_scheduler_if.master bus
);
   if (N_BALLS < 2) begin : g_bad_n
      $error("collision_scheduler needs N_BALLS >= 2");
   end
   localparam logic [21:0] LIM = 22'(BALL_D * BALL_D);
   typedef enum logic [2:0] {IDLE, LOAD, TEST, REQ, NEXT, DONE} state_t;
   state_t            state, state_n;
   logic [IDX_W-1:0]  a, b;
   logic [9:0]        xa_r, ya_r, xb_r, yb_r;
   logic signed [10:0] dx, dy;
   logic signed [20:0] dxe, dye;
   logic [20:0]       dx2, dy2;
   logic [21:0]       dsq;
   logic              ov, hit, last, res_req, busy, done;
   logic [7:0]        hit_count;
   assign dx   = $signed({1'b0, xb_r}) - $signed({1'b0, xa_r});
   assign dy   = $signed({1'b0, yb_r}) - $signed({1'b0, ya_r});
   assign dxe  = 21'(dx);
   assign dye  = 21'(dy);
   assign dx2  = dxe * dxe;
   assign dy2  = dye * dye;
   assign dsq  = {1'b0, dx2} + {1'b0, dy2};
   assign ov   = dsq <= LIM;
   assign last = a == IDX_W'(N_BALLS - 2) && b == IDX_W'(N_BALLS - 1);
`ifdef COLLISION_COOLDOWN_EN
   localparam int NP = N_BALLS * (N_BALLS - 1) / 2;
   localparam int PW = NP > 1 ? $clog2(NP) : 1;
   logic [PW-1:0] p;
   logic [NP-1:0] mask;
   assign hit = ov && !mask[p];
   // A pair stays masked from its first resolved contact until a frame sees it apart.
   always_ff @(posedge clk) begin
      if (rst) begin
         p    <= '0;
         mask <= '0;
      end else begin
         if (state == IDLE && bus.start) p <= '0;
         if (state == NEXT) p <= p + PW'(1);
         if (state == TEST) mask[p] <= ov;
      end
   end
`else
   assign hit = ov;
`endif
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start ? LOAD : IDLE;
         LOAD:    state_n = TEST;
         TEST:    state_n = hit ? REQ : NEXT;
         REQ:     state_n = bus.res_ack ? NEXT : REQ;
         NEXT:    state_n = last ? DONE : LOAD;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a         <= '0;
         b         <= '0;
         xa_r      <= '0;
         ya_r      <= '0;
         xb_r      <= '0;
         yb_r      <= '0;
         res_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit_count <= '0;
      end else begin
         done <= state == DONE;
         if (state == IDLE && bus.start) begin
            a         <= '0;
            b         <= IDX_W'(1);
            hit_count <= '0;
            busy      <= 1'b1;
         end
         if (state == LOAD) begin
            xa_r <= bus.xa;
            ya_r <= bus.ya;
            xb_r <= bus.xb;
            yb_r <= bus.yb;
         end
         if (state == TEST && hit) res_req <= 1'b1;
         if (state == REQ && bus.res_ack) begin
            res_req   <= 1'b0;
            hit_count <= hit_count + 8'(hit_count != 8'hff);
         end
         if (state == NEXT && !last) begin
            a <= b == IDX_W'(N_BALLS - 1) ? a + IDX_W'(1) : a;
            b <= b == IDX_W'(N_BALLS - 1) ? a + IDX_W'(2) : b + IDX_W'(1);
         end
         if (state == DONE) busy <= 1'b0;
      end
   end
   assign bus.rd_a_idx  = a;
   assign bus.rd_b_idx  = b;
   assign bus.res_a_idx = a;
   assign bus.res_b_idx = b;
   assign bus.res_req   = res_req;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.hit_count = hit_count;
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: table-driven frames against hand-computed pair/timing results,
// plus hand sequences for reset-abort, dropped starts and the contact cooldown.
module tb_collision_scheduler;
   logic clk, rst;
   int   checks = 0, errors = 0;
`ifdef COLLISION_COOLDOWN_EN
   localparam bit CD = 1'b1;
`else
   localparam bit CD = 1'b0;
`endif
   collision_scheduler_if #(.IDX_W(2)) bus();
   collision_scheduler #(.N_BALLS(4), .IDX_W(2), .BALL_D(24)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [3:0][9:0] bx, by;
   assign bus.xa = bx[bus.rd_a_idx];
   assign bus.ya = by[bus.rd_a_idx];
   assign bus.xb = bx[bus.rd_b_idx];
   assign bus.yb = by[bus.rd_b_idx];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0][9:0] x, y;
      int              ack, st_at, cyc, hits;
      logic [5:0][3:0] pairs;
   } vec_t;
   vec_t v[8];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      bus.start = 1'b0;
      bus.res_ack = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_state", {bus.res_req, bus.busy, bus.done, bus.hit_count, bus.rd_a_idx,
                            bus.rd_b_idx, bus.res_a_idx, bus.res_b_idx}, 64'd0);
   endtask
   // ack=0 holds res_ack high for the whole frame; otherwise ack rises on the ack-th REQ cycle.
   task automatic run_frame(input int ack, input int st_at, output int cyc, output int nreq,
                            output int rq, output logic [5:0][3:0] pairs);
      int w = 0;
      nreq = 0;
      rq = 0;
      pairs = '0;
      bus.res_ack = ack == 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 400) begin
         if (bus.res_req) begin
            if (w == 0 && nreq < 6) begin
               pairs[nreq] = {bus.res_a_idx, bus.res_b_idx};
               nreq++;
            end
            w++;
            rq++;
            bus.res_ack = ack == 0 || w >= ack;
         end else begin
            w = 0;
            bus.res_ack = ack == 0;
         end
         bus.start = cyc == st_at;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      bus.res_ack = 1'b0;
   endtask
   int cyc, nreq, rq, n;
   logic [5:0][3:0] pr;
   logic saw;
   initial begin
      v[0] = '{{10'd300, 10'd200, 10'd100, 10'd20}, {10'd50, 10'd50, 10'd50, 10'd50}, 1, 18, 19, 0, 24'h000000};
      v[1] = '{{10'd500, 10'd300, 10'd124, 10'd100}, {10'd50, 10'd300, 10'd100, 10'd100}, 5, -1, 24, 1, 24'h000001};
      v[2] = '{{10'd500, 10'd300, 10'd125, 10'd100}, {10'd50, 10'd300, 10'd100, 10'd100}, 1, -1, 19, 0, 24'h000000};
      v[3] = '{{10'd500, 10'd300, 10'd90, 10'd100}, {10'd50, 10'd300, 10'd100, 10'd100}, 1, -1, 20, 1, 24'h000001};
      v[4] = '{{10'd240, 10'd220, 10'd200, 10'd20}, {10'd200, 10'd200, 10'd200, 10'd400}, 0, -1, 21, 2, 24'h0000b6};
      v[5] = '{{10'd616, 10'd600, 10'd0, 10'd0}, {10'd617, 10'd600, 10'd24, 10'd0}, 2, -1, 23, 2, 24'h0000b1};
      v[6] = '{{10'd1000, 10'd1023, 10'd1023, 10'd0}, {10'd0, 10'd0, 10'd1023, 10'd0}, 1, -1, 20, 1, 24'h00000b};
      v[7] = '{{10'd110, 10'd100, 10'd110, 10'd100}, {10'd110, 10'd110, 10'd100, 10'd100}, 1, 5, 25, 6, 24'hb76321};
      bx = v[0].x;
      by = v[0].y;
      for (int i = 0; i < 8; i++) begin
         do_reset();
         bx = v[i].x;
         by = v[i].y;
         run_frame(v[i].ack, v[i].st_at, cyc, nreq, rq, pr);
         check($sformatf("v%0d_done_cycle", i), 64'(cyc), 64'(v[i].cyc));
         check($sformatf("v%0d_hit_count", i), 64'(bus.hit_count), 64'(v[i].hits));
         check($sformatf("v%0d_req_count", i), 64'(nreq), 64'(v[i].hits));
         check($sformatf("v%0d_req_pairs", i), 64'(pr), 64'(v[i].pairs));
         check($sformatf("v%0d_req_cycles", i), 64'(rq), 64'(v[i].hits * (v[i].ack == 0 ? 1 : v[i].ack)));
         check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
         @(negedge clk);
         check($sformatf("v%0d_idle_after", i), 64'({bus.busy, bus.done, bus.res_req}), 64'd0);
         @(negedge clk);
         check($sformatf("v%0d_no_requeue", i), 64'(bus.busy), 64'd0);
      end
      do_reset();
      bx = v[1].x;
      by = v[1].y;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!bus.res_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_req_seen", 64'(bus.res_req), 64'd1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_after_rst", 64'({bus.res_req, bus.busy, bus.done, bus.hit_count}), 64'd0);
      saw = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done || bus.busy || bus.res_req) saw = 1'b1;
      end
      check("abort_quiet", 64'(saw), 64'd0);
      run_frame(5, -1, cyc, nreq, rq, pr);
      check("abort_clean_cycle", 64'(cyc), 64'd24);
      check("abort_clean_hits", 64'(bus.hit_count), 64'd1);
      do_reset();
      for (int f = 0; f < 5; f++) begin
         bx = f == 3 ? v[2].x : v[1].x;
         by = f == 3 ? v[2].y : v[1].y;
         run_frame(1, -1, cyc, nreq, rq, pr);
         n = f == 3 ? 0 : (CD && (f == 1 || f == 2)) ? 0 : 1;
         check($sformatf("cool_f%0d_reqs", f), 64'(nreq), 64'(n));
         check($sformatf("cool_f%0d_hits", f), 64'(bus.hit_count), 64'(n));
         check($sformatf("cool_f%0d_cycle", f), 64'(cyc), 64'(19 + n));
         @(negedge clk);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
